// File: rtl/fmult_seq.sv
// fmult_seq: sequential IEEE-754 single-precision multiplier.
// A shift-add datapath consumes BITS_PER_CYCLE multiplier bits per cycle,
// then one NORM cycle builds the truncated result and one DONE cycle
// presents it. Optional macro FMULT_SEQ_SPECIAL_EN enables NaN/Inf/zero
// handling and exponent overflow/underflow saturation in NORM.
module fmult_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam int N_ITER = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_CNT = 5'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [23:0] r_ma;
    logic [23:0] r_mb;
    logic [47:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_out;

    logic [47:0] w_partial;
    logic [5:0]  w_shamt;
    logic [47:0] w_addend;
    logic [22:0] w_frac;
    logic [31:0] w_result;
    logic        w_unused_bits;

`ifdef FMULT_SEQ_SPECIAL_EN
    logic               r_fa_nz;
    logic               r_fb_nz;
    logic signed [9:0]  w_exp;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
`else
    logic [7:0]         w_exp;
`endif

    // Partial product of the multiplicand with the current multiplier chunk,
    // placed at the weight of the chunk being consumed this iteration.
    assign w_partial     = 48'(r_ma) * 48'(r_mb[BITS_PER_CYCLE-1:0]);
    assign w_shamt       = 6'(r_cnt) * 6'(BITS_PER_CYCLE);
    assign w_addend      = w_partial << w_shamt;
    assign w_unused_bits = ^r_acc[22:0];

    // Normalisation and result assembly from the finished product.
    always_comb begin
        w_frac   = 23'd0;
        w_result = 32'd0;
        if (r_acc[47]) begin
            w_frac = r_acc[46:24];
        end else begin
            w_frac = r_acc[45:23];
        end
`ifdef FMULT_SEQ_SPECIAL_EN
        w_a_nan  = (r_ea == 8'hFF) && r_fa_nz;
        w_b_nan  = (r_eb == 8'hFF) && r_fb_nz;
        w_a_inf  = (r_ea == 8'hFF) && !r_fa_nz;
        w_b_inf  = (r_eb == 8'hFF) && !r_fb_nz;
        w_a_zero = (r_ea == 8'h00);
        w_b_zero = (r_eb == 8'h00);
        w_exp    = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127
                   + $signed({9'd0, r_acc[47]});
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_result = 32'h7FC00000;
        end else if (w_a_inf || w_b_inf) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (w_a_zero || w_b_zero) begin
            w_result = {r_sign, 31'd0};
        end else if (w_exp >= 10'sd255) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            w_result = {r_sign, 31'd0};
        end else begin
            w_result = {r_sign, w_exp[7:0], w_frac};
        end
`else
        // Exponent wraps modulo 256: no special-value handling in this build.
        w_exp    = r_ea + r_eb - 8'd127 + {7'd0, r_acc[47]};
        w_result = {r_sign, w_exp, w_frac};
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: start is only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_MULT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MULT: begin
                if (r_cnt == LAST_CNT) begin
                    w_next = S_NORM;
                end else begin
                    w_next = S_MULT;
                end
            end
            S_NORM:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, shift-add accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign  <= 1'b0;
            r_ea    <= 8'd0;
            r_eb    <= 8'd0;
            r_ma    <= 24'd0;
            r_mb    <= 24'd0;
            r_acc   <= 48'd0;
            r_cnt   <= 5'd0;
            r_out   <= 32'd0;
`ifdef FMULT_SEQ_SPECIAL_EN
            r_fa_nz <= 1'b0;
            r_fb_nz <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign  <= a[31] ^ b[31];
                        r_ea    <= a[30:23];
                        r_eb    <= b[30:23];
                        r_ma    <= {1'b1, a[22:0]};
                        r_mb    <= {1'b1, b[22:0]};
                        r_acc   <= 48'd0;
                        r_cnt   <= 5'd0;
`ifdef FMULT_SEQ_SPECIAL_EN
                        r_fa_nz <= (a[22:0] != 23'd0);
                        r_fb_nz <= (b[22:0] != 23'd0);
`endif
                    end
                end
                S_MULT: begin
                    r_acc <= r_acc + w_addend;
                    r_mb  <= r_mb >> BITS_PER_CYCLE;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    r_out <= w_result;
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign out  = r_out;

endmodule
